// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side arbitration logic.
//   ramstate_t  : handshake state reported by the RAM port
//   arb_state_t : ram_arbiter FSM states
//   REQ_*       : default requester slot assignment
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Default requester mapping onto the arbiter slots.
  localparam int REQ_I0 = 0;  // cpu0 icache
  localparam int REQ_D0 = 1;  // cpu0 dcache
  localparam int REQ_I1 = 2;  // cpu1 icache
  localparam int REQ_D1 = 3;  // cpu1 dcache

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select, shared with the snoop-bus arbiter.
// Ports:
//   active   : one bit per requester wanting service
//   prio_ptr : index that has highest priority this round
//   found    : at least one requester is active
//   winner   : first active index scanning prio_ptr, prio_ptr+1, ... mod NREQ
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         active,
  input  logic [$clog2(NREQ)-1:0] prio_ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    found  = |active;
    winner = '0;
    // Scan from the farthest offset down so the nearest active index to
    // prio_ptr is written last and wins. IW-bit addition wraps modulo NREQ.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (active[prio_ptr + IW'(i)]) winner = prio_ptr + IW'(i);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// A grant covers a 1- or 2-word burst; priority rotates past the granted
// requester after every finished grant (completion, error or abort).
// Ports:
//   CLK, nRST                : clock, asynchronous active-low reset
//   req_ren/req_wen          : per-requester read/write request (write wins)
//   req_burst                : 0 = one word, 1 = two words (addr, addr+4)
//   req_addr/req_wdata       : per-requester start address / live write data
//   req_wait                 : low for exactly one cycle per completed beat
//   req_err                  : one-cycle pulse when the RAM reports ERROR
//   req_rdata                : RAM read data passed through during a grant
//   gnt_valid/gnt_idx        : grant active / granted requester
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate : RAM port
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NREQ-1:0]                req_ren,
  input  logic [NREQ-1:0]                req_wen,
  input  logic [NREQ-1:0]                req_burst,
  input  logic [NREQ-1:0][AW-1:0]        req_addr,
  input  logic [NREQ-1:0][DW-1:0]        req_wdata,
  output logic [NREQ-1:0]                req_wait,
  output logic [NREQ-1:0]                req_err,
  output logic [DW-1:0]                  req_rdata,
  output logic                           gnt_valid,
  output logic [$clog2(NREQ)-1:0]        gnt_idx,
  output logic                           ramREN,
  output logic                           ramWEN,
  output logic [AW-1:0]                  ramaddr,
  output logic [DW-1:0]                  ramstore,
  input  logic [DW-1:0]                  ramload,
  input  ramstate_t                      ramstate
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   prio_q, prio_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            beat_q, beat_d;
  logic [AW-1:0]   base_q, base_d;
  logic            wr_q, wr_d;
  logic            two_q, two_d;   // burst of two words latched at grant

  logic [NREQ-1:0] active;
  logic            found;
  logic [IW-1:0]   winner;
  logic            live;           // granted requester still requesting

  assign active = req_ren | req_wen;
  assign live   = active[gnt_q];

  rr_picker #(.NREQ(NREQ)) u_pick (
    .active   (active),
    .prio_ptr (prio_q),
    .found    (found),
    .winner   (winner)
  );

  assign gnt_valid = (state_q == XFER);
  assign gnt_idx   = gnt_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wr_d      = wr_q;
    two_d     = two_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    req_rdata = '0;
    req_wait  = '1;
    req_err   = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = winner;
          base_d  = req_addr[winner];
          wr_d    = req_wen[winner];
          two_d   = req_burst[winner];
          beat_d  = 1'b0;
          state_d = XFER;
        end
      end

      XFER: begin
        // Address wraps modulo 2^AW by plain truncation.
        ramaddr   = base_q + {{(AW-3){1'b0}}, beat_q, 2'b00};
        ramstore  = req_wdata[gnt_q];
        req_rdata = ramload;
        if (!live) begin
          // Requester gave up: enables stay low this cycle, no wait pulse.
          state_d = RELEASE;
          prio_d  = gnt_q + 1'b1;
        end else begin
          ramWEN = wr_q;
          ramREN = !wr_q;
          if (ramstate == ACCESS) begin
            req_wait[gnt_q] = 1'b0;
            beat_d          = beat_q + 1'b1;
            if (beat_q == two_q) begin
              state_d = RELEASE;
              prio_d  = gnt_q + 1'b1;
            end
          end else if (ramstate == ERROR) begin
            req_err[gnt_q] = 1'b1;
            state_d        = RELEASE;
            prio_d         = gnt_q + 1'b1;
          end
        end
      end

      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (!nRST) begin
      state_q <= IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
      beat_q  <= 1'b0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      two_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      two_q   <= two_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a transaction-level model predicts
// every output on every negedge; directed scenarios pin key literal values,
// then a randomized phase exercises contention, errors, aborts and resets.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                    CLK = 1'b0;
  logic                    nRST = 1'b0;
  logic [NREQ-1:0]         req_ren, req_wen, req_burst;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_wdata;
  logic [NREQ-1:0]         req_wait, req_err;
  logic [DW-1:0]           req_rdata;
  logic                    gnt_valid;
  logic [1:0]              gnt_idx;
  logic                    ramREN, ramWEN;
  logic [AW-1:0]           ramaddr;
  logic [DW-1:0]           ramstore, ramload;
  ramstate_t               ramstate;

  ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_burst(req_burst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wait(req_wait), .req_err(req_err), .req_rdata(req_rdata),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  int          m_owner = -1;   // requester holding the RAM, -1 when none
  bit          m_dead  = 1'b0; // one idle dead cycle owed after a grant ends
  int          m_ptr   = 0;    // requester with top priority
  int          m_last  = 0;    // most recently granted requester
  int          m_done  = 0;    // beats completed in the current grant
  int          m_len   = 1;    // beats in the current grant
  bit          m_wr    = 1'b0;
  logic [31:0] m_base  = '0;
  bit          m_live;

  task automatic m_end_grant();
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_dead  = 1'b1;
  endtask

  initial begin : model
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
        m_owner = -1; m_dead = 1'b0; m_ptr = 0; m_last = 0;
      end else if (m_owner >= 0) begin
        m_live = req_ren[m_owner] | req_wen[m_owner];
        if (!m_live || ramstate == ERROR) m_end_grant();
        else if (ramstate == ACCESS) begin
          m_done++;
          if (m_done == m_len) m_end_grant();
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_ptr + k) % NREQ;
          if (req_ren[i] | req_wen[i]) begin
            m_owner = i; m_last = i; m_done = 0;
            m_wr    = req_wen[i];
            m_base  = req_addr[i];
            m_len   = req_burst[i] ? 2 : 1;
            break;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin : compare
    int          g;
    bit          e_valid, e_live;
    logic [31:0] e_addr;
    logic [3:0]  e_wait, e_err;
    forever begin
      @(negedge CLK);
      e_valid = (m_owner >= 0);
      g       = e_valid ? m_owner : m_last;
      e_live  = e_valid && (req_ren[g] | req_wen[g]);
      e_addr  = e_valid ? m_base + 32'(4 * m_done) : 32'h0;
      e_wait  = 4'hF;
      e_err   = 4'h0;
      if (e_live && ramstate == ACCESS) e_wait[g] = 1'b0;
      if (e_live && ramstate == ERROR)  e_err[g]  = 1'b1;
      check("gnt_valid", gnt_valid, e_valid);
      check("gnt_idx",   gnt_idx,   g);
      check("ramREN",    ramREN,    e_live && !m_wr);
      check("ramWEN",    ramWEN,    e_live && m_wr);
      check("ramaddr",   ramaddr,   e_addr);
      check("ramstore",  ramstore,  e_valid ? req_wdata[g] : 32'h0);
      check("req_rdata", req_rdata, e_valid ? ramload : 32'h0);
      check("req_wait",  req_wait,  e_wait);
      check("req_err",   req_err,   e_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (!gnt_valid && n < 8) begin
      @(negedge CLK);
      n++;
    end
    check(name, gnt_valid, 1'b1);
  endtask

  int order[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req_ren = '0; req_wen = '0; req_burst = '0;
    req_addr = '0; req_wdata = '0;
    ramload = '0; ramstate = FREE;

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt_valid", gnt_valid, 1'b0);
    check("rst_wait", req_wait, 4'hF);
    check("rst_ramaddr", ramaddr, 32'h0);
    tick();
    nRST = 1'b1;

    // Single 1-word read, two BUSY cycles then ACCESS
    req_ren = 4'b0001; req_addr[0] = 32'h100; ramstate = BUSY;
    @(negedge CLK); check("t1_no_early_ren", ramREN, 1'b0);
    tick(); @(negedge CLK);
    check("t1_ren", ramREN, 1'b1);
    check("t1_addr", ramaddr, 32'h100);
    check("t1_busy_wait", req_wait, 4'hF);
    tick(); @(negedge CLK); check("t1_busy2_wait", req_wait, 4'hF);
    tick(); ramstate = ACCESS; ramload = 32'hDEAD_0001;
    @(negedge CLK);
    check("t1_wait_low", req_wait, 4'b1110);
    check("t1_rdata", req_rdata, 32'hDEAD_0001);
    tick(); req_ren = '0; ramstate = FREE;
    @(negedge CLK); check("t1_release", gnt_valid, 1'b0);
    check("t1_release_ren", ramREN, 1'b0);
    tick();

    // 2-word write burst, live write data
    req_wen = 4'b0010; req_burst = 4'b0010; req_addr[1] = 32'h1F8;
    req_wdata[1] = 32'hAAAA_0001; ramstate = ACCESS;
    @(negedge CLK); check("t2_idle_wen", ramWEN, 1'b0);
    tick(); @(negedge CLK);
    check("t2_wen", ramWEN, 1'b1);
    check("t2_addr0", ramaddr, 32'h1F8);
    check("t2_store0", ramstore, 32'hAAAA_0001);
    check("t2_wait0", req_wait, 4'b1101);
    tick(); req_wdata[1] = 32'hBBBB_0002;
    @(negedge CLK);
    check("t2_addr1", ramaddr, 32'h1FC);
    check("t2_store1", ramstore, 32'hBBBB_0002);
    check("t2_wait1", req_wait, 4'b1101);
    tick(); req_wen = '0; req_burst = '0;
    @(negedge CLK); check("t2_release", gnt_valid, 1'b0);
    tick();

    // Contention fairness from a fresh priority pointer
    nRST = 1'b0;
    tick();
    nRST = 1'b1; req_ren = 4'b1111; ramstate = ACCESS;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (gnt_valid) order.push_back(int'(gnt_idx));
      tick();
    end
    req_ren = '0;
    check("t3_grant_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) check($sformatf("t3_order%0d", i), order[i], exp_order[i]);

    // Write wins over read; address wraps on the second beat
    req_ren = 4'b1000; req_wen = 4'b1000; req_burst = 4'b1000;
    req_addr[3] = 32'hFFFF_FFFC; req_wdata[3] = 32'h1234_5678;
    wait_grant("t4_grant");
    check("t4_idx", gnt_idx, 2'd3);
    check("t4_wen", ramWEN, 1'b1);
    check("t4_ren", ramREN, 1'b0);
    check("t4_addr0", ramaddr, 32'hFFFF_FFFC);
    tick(); @(negedge CLK);
    check("t4_addr_wrap", ramaddr, 32'h0000_0000);
    check("t4_wait1", req_wait, 4'b0111);
    tick(); req_ren = '0; req_wen = '0; req_burst = '0;

    // Error on beat 0 of requester 2; next grant goes to 3
    req_ren = 4'b1100; ramstate = ERROR;
    wait_grant("t5_grant2");
    check("t5_idx2", gnt_idx, 2'd2);
    check("t5_err", req_err, 4'b0100);
    check("t5_err_wait", req_wait, 4'hF);
    tick(); ramstate = ACCESS;
    @(negedge CLK); check("t5_err_once", req_err, 4'h0);
    wait_grant("t5_grant3");
    check("t5_idx3", gnt_idx, 2'd3);
    tick(); req_ren = '0; ramstate = FREE;

    // Requester 0 abandons its burst: enables drop in the same cycle
    req_ren = 4'b0001; req_burst = 4'b0001; req_addr[0] = 32'h40; ramstate = BUSY;
    wait_grant("t5b_grant");
    check("t5b_ren", ramREN, 1'b1);
    tick(); req_ren = '0;
    @(negedge CLK);
    check("t5b_ren_drop", ramREN, 1'b0);
    check("t5b_still_valid", gnt_valid, 1'b1);
    check("t5b_no_wait_pulse", req_wait, 4'hF);
    tick(); @(negedge CLK); check("t5b_release", gnt_valid, 1'b0);
    tick(); req_burst = '0;

    // Asynchronous reset in the middle of beat 1
    req_wen = 4'b0010; req_burst = 4'b0010; req_addr[1] = 32'h800; ramstate = ACCESS;
    wait_grant("t6_grant");
    tick();
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_valid", gnt_valid, 1'b0);
    check("t6_rst_wen", ramWEN, 1'b0);
    check("t6_rst_addr", ramaddr, 32'h0);
    check("t6_rst_wait", req_wait, 4'hF);
    req_wen = '0; req_burst = '0;
    tick(); tick();
    nRST = 1'b1; req_ren = 4'b0101;
    wait_grant("t6_regrant");
    check("t6_prio_reset", gnt_idx, 2'd0);
    tick(); req_ren = '0;

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      nRST = ($urandom_range(599) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(3) == 0) begin
          req_ren[i]   = $urandom_range(1);
          req_wen[i]   = ($urandom_range(2) == 0);
          req_burst[i] = $urandom_range(1);
          req_addr[i]  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        end
        req_wdata[i] = $urandom();
      end
      ramload = $urandom();
      r = $urandom_range(9);
      ramstate = (r < 2) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACCESS : ERROR;
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
